// File: rtl/execute_pipe_n_if.sv
// Issue/writeback bundle for execute_pipe_n: master = issue side, slave = execute pipe.
// Issue has no ready: an op is taken on any edge where functionalunit matches and flush is low.
interface execute_pipe_n_if #(
  parameter int STAGES = 4,
  parameter int REG_W  = 5
);
  localparam int CW = $clog2(STAGES + 1);

  logic [1:0]       is_x_functionalunit;
  logic             is_x_selalushift;
  logic             is_x_selimregb;
  logic [2:0]       is_x_aluop;
  logic             is_x_unsig;
  logic [1:0]       is_x_shiftop;
  logic [4:0]       is_x_shiftamt;
  logic [31:0]      is_x_rega;
  logic [31:0]      is_x_regb;
  logic [31:0]      is_x_imedext;
  logic [REG_W-1:0] is_x_regdest;
  logic             is_x_writereg;
  logic             is_x_writeov;
  logic             x_flush;
  logic [REG_W-1:0] x_busy_query;
  logic             x_busy;
  logic [CW-1:0]    x_busy_cycles;
  logic [CW-1:0]    x_inflight;
  logic             x_fwd_valid;
  logic [31:0]      x_fwd_value;
  logic [REG_W-1:0] x_wb_regdest;
  logic             x_wb_writereg;
  logic [31:0]      x_wb_wbvalue;

  modport master (
    output is_x_functionalunit, is_x_selalushift, is_x_selimregb, is_x_aluop,
           is_x_unsig, is_x_shiftop, is_x_shiftamt, is_x_rega, is_x_regb,
           is_x_imedext, is_x_regdest, is_x_writereg, is_x_writeov,
           x_flush, x_busy_query,
    input  x_busy, x_busy_cycles, x_inflight, x_fwd_valid, x_fwd_value,
           x_wb_regdest, x_wb_writereg, x_wb_wbvalue
  );

  modport slave (
    input  is_x_functionalunit, is_x_selalushift, is_x_selimregb, is_x_aluop,
           is_x_unsig, is_x_shiftop, is_x_shiftamt, is_x_rega, is_x_regb,
           is_x_imedext, is_x_regdest, is_x_writereg, is_x_writeov,
           x_flush, x_busy_query,
    output x_busy, x_busy_cycles, x_inflight, x_fwd_valid, x_fwd_value,
           x_wb_regdest, x_wb_writereg, x_wb_wbvalue
  );
endinterface

// File: rtl/execute_pipe_n.sv
// Integer execute pipe: ALU/shifter in stage 0, then STAGES-1 register stages to writeback.
// Define EXECUTE_PIPE_FWD_EN to build the youngest-match forwarding mux on x_fwd_*.
module execute_pipe_n #(
  parameter int FU_ID  = 1,
  parameter int STAGES = 4,
  parameter int REG_W  = 5
) (
  input logic             clock,
  input logic             reset,
  execute_pipe_n_if.slave bus
);
  localparam int CW = $clog2(STAGES + 1);
  localparam logic [1:0] FU_CODE = 2'(FU_ID);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] regdest;
    logic             writereg;
    logic [31:0]      wbvalue;
  } stage_t;

  stage_t        p      [STAGES];
  stage_t        p_next [STAGES];
  logic [CW-1:0] inflight;
  logic [CW-1:0] inflight_next;
  logic [31:0]   op_b;
  logic [31:0]   alu_res;
  logic [31:0]   shift_res;
  logic          alu_ov;
  logic          accept;
  logic          busy;
  logic [CW-1:0] busy_cycles;

  function automatic logic stage_hit(stage_t s, logic [REG_W-1:0] q);
    return s.valid & s.writereg & (s.regdest == q) & (q != '0);
  endfunction

  // ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 slt/sltu, 7 pass B.
  // Overflow is only raised by signed add/sub.
  always_comb begin
    op_b    = bus.is_x_selimregb ? bus.is_x_imedext : bus.is_x_regb;
    alu_res = '0;
    alu_ov  = 1'b0;
    case (bus.is_x_aluop)
      3'd0: begin
        alu_res = bus.is_x_rega + op_b;
        alu_ov  = ~bus.is_x_unsig & (bus.is_x_rega[31] == op_b[31]) &
                  (alu_res[31] != bus.is_x_rega[31]);
      end
      3'd1: begin
        alu_res = bus.is_x_rega - op_b;
        alu_ov  = ~bus.is_x_unsig & (bus.is_x_rega[31] != op_b[31]) &
                  (alu_res[31] != bus.is_x_rega[31]);
      end
      3'd2: alu_res = bus.is_x_rega & op_b;
      3'd3: alu_res = bus.is_x_rega | op_b;
      3'd4: alu_res = bus.is_x_rega ^ op_b;
      3'd5: alu_res = ~(bus.is_x_rega | op_b);
      3'd6: alu_res = bus.is_x_unsig ? 32'(bus.is_x_rega < op_b)
                                     : 32'($signed(bus.is_x_rega) < $signed(op_b));
      default: alu_res = op_b;
    endcase
  end

  // Shifter works on regb: 0 sll, 1 srl, 2 sra, 3 rotate right.
  always_comb begin
    shift_res = '0;
    case (bus.is_x_shiftop)
      2'd0: shift_res = bus.is_x_regb << bus.is_x_shiftamt;
      2'd1: shift_res = bus.is_x_regb >> bus.is_x_shiftamt;
      2'd2: shift_res = $signed(bus.is_x_regb) >>> bus.is_x_shiftamt;
      default: shift_res = (bus.is_x_regb >> bus.is_x_shiftamt) |
                           (bus.is_x_regb << (6'd32 - {1'b0, bus.is_x_shiftamt}));
    endcase
  end

  always_comb begin
    accept    = (bus.is_x_functionalunit == FU_CODE) & ~bus.x_flush;
    p_next[0] = '0;
    if (accept) begin
      p_next[0].valid    = 1'b1;
      p_next[0].regdest  = bus.is_x_regdest;
      p_next[0].writereg = bus.is_x_writereg & (~alu_ov | bus.is_x_writeov);
      p_next[0].wbvalue  = bus.is_x_selalushift ? shift_res : alu_res;
    end
    for (int k = 1; k < STAGES; k++) p_next[k] = p[k-1];
    if (bus.x_flush) begin
      for (int k = 0; k < STAGES; k++) p_next[k] = '0;
    end
    inflight_next = '0;
    for (int k = 0; k < STAGES; k++) inflight_next = inflight_next + CW'(p_next[k].valid);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < STAGES; k++) p[k] <= '0;
      inflight <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) p[k] <= p_next[k];
      inflight <= inflight_next;
    end
  end

  // The writeback stage is excluded: its write lands this cycle, so issue need not wait.
  always_comb begin
    busy        = 1'b0;
    busy_cycles = '0;
    for (int k = STAGES - 2; k >= 0; k--) begin
      if (stage_hit(p[k], bus.x_busy_query)) begin
        busy        = 1'b1;
        busy_cycles = CW'(STAGES - 1 - k);
      end
    end
  end

`ifdef EXECUTE_PIPE_FWD_EN
  logic        fwd_valid;
  logic [31:0] fwd_value;

  always_comb begin
    fwd_valid = 1'b0;
    fwd_value = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (stage_hit(p[k], bus.x_busy_query)) begin
        fwd_valid = 1'b1;
        fwd_value = p[k].wbvalue;
      end
    end
  end

  assign bus.x_fwd_valid = fwd_valid;
  assign bus.x_fwd_value = fwd_value;
`else
  assign bus.x_fwd_valid = 1'b0;
  assign bus.x_fwd_value = '0;
`endif

  assign bus.x_busy        = busy;
  assign bus.x_busy_cycles = busy_cycles;
  assign bus.x_inflight    = inflight;
  assign bus.x_wb_regdest  = p[STAGES-1].regdest;
  assign bus.x_wb_writereg = p[STAGES-1].valid & p[STAGES-1].writereg;
  assign bus.x_wb_wbvalue  = p[STAGES-1].wbvalue;
endmodule

// File: tb/tb_execute_pipe_n.sv
// Bench for execute_pipe_n: vector table, directed hazard/flush/reset sequences, random vs queue model.
module tb_execute_pipe_n;
  localparam int STAGES = 4;
  localparam int REG_W  = 5;
  localparam int FU_ID  = 1;
  localparam int CW     = $clog2(STAGES + 1);
  localparam int EW     = REG_W + 33;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  execute_pipe_n_if #(.STAGES(STAGES), .REG_W(REG_W)) bus ();

  execute_pipe_n #(.FU_ID(FU_ID), .STAGES(STAGES), .REG_W(REG_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]       fu;
    logic [2:0]       aluop;
    logic             unsig;
    logic             sel_sh;
    logic             sel_imm;
    logic [1:0]       shop;
    logic [4:0]       amt;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [31:0]      imm;
    logic [REG_W-1:0] rd;
    logic             wr;
    logic             wov;
  } issue_t;

  typedef struct {
    issue_t           op;
    logic [REG_W-1:0] exp_rd;
    logic             exp_wr;
    logic [31:0]      exp_val;
  } vec_t;

  // Scoreboard: each entry {regdest, writereg, value}, with its age in edges since issue.
  logic [EW-1:0] exp_q[$];
  int            age_q[$];

  function automatic issue_t mk(logic [1:0] fu, logic [2:0] aluop, logic unsig, logic sel_sh,
                                logic sel_imm, logic [1:0] shop, logic [4:0] amt,
                                logic [31:0] a, logic [31:0] b, logic [31:0] imm,
                                logic [REG_W-1:0] rd, logic wr, logic wov);
    issue_t o;
    o.fu = fu; o.aluop = aluop; o.unsig = unsig; o.sel_sh = sel_sh; o.sel_imm = sel_imm;
    o.shop = shop; o.amt = amt; o.a = a; o.b = b; o.imm = imm; o.rd = rd; o.wr = wr; o.wov = wov;
    return o;
  endfunction

  function automatic logic [32:0] ref_alu(logic [2:0] op, logic uns, logic [31:0] a, logic [31:0] b);
    longint sa, sb, r, max_s, min_s;
    logic [31:0] res;
    logic ov;
    max_s = 64'sd2147483647;
    min_s = -64'sd2147483648;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ov = 1'b0;
    res = '0;
    case (op)
      3'd0: begin r = sa + sb; res = 32'(r); ov = !uns && (r > max_s || r < min_s); end
      3'd1: begin r = sa - sb; res = 32'(r); ov = !uns && (r > max_s || r < min_s); end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: res = ~(a | b);
      3'd6: res = uns ? 32'(a < b) : 32'(sa < sb);
      default: res = b;
    endcase
    return {ov, res};
  endfunction

  function automatic logic [31:0] ref_shift(logic [1:0] op, logic [4:0] amt, logic [31:0] b);
    logic [31:0] r;
    case (op)
      2'd0: r = b << amt;
      2'd1: r = b >> amt;
      2'd2: r = 32'(longint'($signed(b)) >>> amt);
      default: begin
        r = b;
        for (int i = 0; i < int'(amt); i++) r = {r[0], r[31:1]};
      end
    endcase
    return r;
  endfunction

  task automatic drive(issue_t o);
    bus.is_x_functionalunit = o.fu;
    bus.is_x_aluop          = o.aluop;
    bus.is_x_unsig          = o.unsig;
    bus.is_x_selalushift    = o.sel_sh;
    bus.is_x_selimregb      = o.sel_imm;
    bus.is_x_shiftop        = o.shop;
    bus.is_x_shiftamt       = o.amt;
    bus.is_x_rega           = o.a;
    bus.is_x_regb           = o.b;
    bus.is_x_imedext        = o.imm;
    bus.is_x_regdest        = o.rd;
    bus.is_x_writereg       = o.wr;
    bus.is_x_writeov        = o.wov;
  endtask

  task automatic idle();
    drive(mk(2'd0, 3'd0, 0, 0, 0, 2'd0, 5'd0, 0, 0, 0, '0, 0, 0));
    bus.x_flush = 1'b0;
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge; the model sees the same inputs the DUT sampled.
  task automatic tick();
    logic fl, acc, wr;
    logic [32:0] ar;
    logic [31:0] val;
    logic [REG_W-1:0] rd;
    fl  = bus.x_flush;
    acc = (bus.is_x_functionalunit == 2'(FU_ID)) && !fl;
    ar  = ref_alu(bus.is_x_aluop, bus.is_x_unsig, bus.is_x_rega,
                  bus.is_x_selimregb ? bus.is_x_imedext : bus.is_x_regb);
    val = bus.is_x_selalushift ? ref_shift(bus.is_x_shiftop, bus.is_x_shiftamt, bus.is_x_regb)
                               : ar[31:0];
    wr  = bus.is_x_writereg && (!ar[32] || bus.is_x_writeov);
    rd  = bus.is_x_regdest;
    @(posedge clock);
    #1;
    if (!reset || fl) begin
      exp_q.delete();
      age_q.delete();
    end else begin
      if (acc) begin
        exp_q.push_back({rd, wr, val});
        age_q.push_back(0);
      end
      for (int i = 0; i < age_q.size(); i++) age_q[i] = age_q[i] + 1;
      while (age_q.size() > 0 && age_q[0] > STAGES) begin
        void'(exp_q.pop_front());
        void'(age_q.pop_front());
      end
    end
  endtask

  task automatic check_model(string tag);
    logic [REG_W-1:0] e_rd, rd, q;
    logic e_wr, wr, e_busy;
    logic [31:0] e_val, val;
    logic [CW-1:0] e_cyc;
    int young;
`ifdef EXECUTE_PIPE_FWD_EN
    logic e_fv;
    logic [31:0] e_fval;
    int fyoung;
    e_fv = 0; e_fval = '0; fyoung = STAGES + 1;
`endif
    e_rd = '0; e_wr = 0; e_val = '0; e_busy = 0; e_cyc = '0; young = STAGES + 1;
    q = bus.x_busy_query;
    for (int i = 0; i < exp_q.size(); i++) begin
      {rd, wr, val} = exp_q[i];
      if (age_q[i] == STAGES) begin e_rd = rd; e_wr = wr; e_val = val; end
      if (wr && rd == q && q != '0) begin
        if (age_q[i] < STAGES && age_q[i] < young) begin
          young = age_q[i]; e_busy = 1; e_cyc = CW'(STAGES - age_q[i]);
        end
`ifdef EXECUTE_PIPE_FWD_EN
        if (age_q[i] < fyoung) begin fyoung = age_q[i]; e_fv = 1; e_fval = val; end
`endif
      end
    end
    check({tag, "_wb_rd"}, 64'(bus.x_wb_regdest), 64'(e_rd));
    check({tag, "_wb_wr"}, 64'(bus.x_wb_writereg), 64'(e_wr));
    check({tag, "_wb_val"}, 64'(bus.x_wb_wbvalue), 64'(e_val));
    check({tag, "_inflight"}, 64'(bus.x_inflight), 64'(exp_q.size()));
    check({tag, "_busy"}, 64'(bus.x_busy), 64'(e_busy));
    check({tag, "_busy_cyc"}, 64'(bus.x_busy_cycles), 64'(e_cyc));
`ifdef EXECUTE_PIPE_FWD_EN
    check({tag, "_fwd_valid"}, 64'(bus.x_fwd_valid), 64'(e_fv));
    check({tag, "_fwd_value"}, 64'(bus.x_fwd_value), 64'(e_fval));
`endif
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i <= STAGES; i++) tick();
  endtask

  function automatic issue_t op_rd(logic [REG_W-1:0] rd, logic [31:0] a);
    return mk(2'd1, 3'd0, 0, 0, 0, 2'd0, 5'd0, a, 32'd1, 0, rd, 1, 0);
  endfunction

  vec_t vecs[18];

  initial begin
    vecs[0]  = '{mk(1, 0, 0, 0, 0, 0, 0, 5, 7, 0, 3, 1, 0), 3, 1, 32'd12};
    vecs[1]  = '{mk(1, 0, 0, 0, 0, 0, 0, 32'h7FFFFFFF, 1, 0, 4, 1, 0), 4, 0, 32'h80000000};
    vecs[2]  = '{mk(1, 0, 0, 0, 0, 0, 0, 32'h7FFFFFFF, 1, 0, 4, 1, 1), 4, 1, 32'h80000000};
    vecs[3]  = '{mk(1, 1, 0, 0, 0, 0, 0, 3, 5, 0, 6, 1, 0), 6, 1, 32'hFFFFFFFE};
    vecs[4]  = '{mk(1, 1, 1, 0, 0, 0, 0, 32'h80000000, 1, 0, 6, 1, 0), 6, 1, 32'h7FFFFFFF};
    vecs[5]  = '{mk(1, 1, 0, 0, 0, 0, 0, 32'h80000000, 1, 0, 6, 1, 0), 6, 0, 32'h7FFFFFFF};
    vecs[6]  = '{mk(1, 2, 0, 0, 1, 0, 0, 32'hF0F0, 0, 32'h0FF0, 7, 1, 0), 7, 1, 32'h00F0};
    vecs[7]  = '{mk(1, 3, 0, 0, 0, 0, 0, 32'hF000, 32'h000F, 0, 8, 1, 0), 8, 1, 32'hF00F};
    vecs[8]  = '{mk(1, 4, 0, 0, 0, 0, 0, 32'hFF, 32'h0F, 0, 9, 1, 0), 9, 1, 32'hF0};
    vecs[9]  = '{mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 10, 1, 0), 10, 1, 32'hFFFFFFFF};
    vecs[10] = '{mk(1, 6, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 1, 0, 11, 1, 0), 11, 1, 32'd1};
    vecs[11] = '{mk(1, 6, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 1, 0, 11, 1, 0), 11, 1, 32'd0};
    vecs[12] = '{mk(1, 2, 0, 1, 0, 0, 4, 0, 1, 0, 12, 1, 0), 12, 1, 32'h10};
    vecs[13] = '{mk(1, 2, 0, 1, 0, 1, 31, 0, 32'h80000000, 0, 13, 1, 0), 13, 1, 32'd1};
    vecs[14] = '{mk(1, 2, 0, 1, 0, 2, 4, 0, 32'h80000000, 0, 14, 1, 0), 14, 1, 32'hF8000000};
    vecs[15] = '{mk(1, 2, 0, 1, 0, 3, 1, 0, 32'h1, 0, 15, 1, 0), 15, 1, 32'h80000000};
    vecs[16] = '{mk(1, 7, 0, 0, 1, 0, 0, 0, 0, 32'h12345678, 16, 1, 0), 16, 1, 32'h12345678};
    vecs[17] = '{mk(0, 0, 0, 0, 0, 0, 0, 5, 7, 0, 17, 1, 0), 0, 0, 32'd0};

    // Reset state
    idle();
    bus.x_busy_query = '0;
    #12;
    check("rst_wb_wr", 64'(bus.x_wb_writereg), 0);
    check("rst_wb_val", 64'(bus.x_wb_wbvalue), 0);
    check("rst_inflight", 64'(bus.x_inflight), 0);
    check("rst_busy", 64'(bus.x_busy), 0);
    @(negedge clock);
    reset = 1'b1;

    // Vector table: exact latency, value and writereg for each op
    foreach (vecs[v]) begin
      drive(vecs[v].op);
      tick();
      idle();
      for (int c = 1; c < STAGES; c++) begin
        check($sformatf("vec%0d_early_wr", v), 64'(bus.x_wb_writereg), 0);
        tick();
      end
      check($sformatf("vec%0d_rd", v), 64'(bus.x_wb_regdest), 64'(vecs[v].exp_rd));
      check($sformatf("vec%0d_wr", v), 64'(bus.x_wb_writereg), 64'(vecs[v].exp_wr));
      check($sformatf("vec%0d_val", v), 64'(bus.x_wb_wbvalue), 64'(vecs[v].exp_val));
    end
    drain();

    // Wrong functional unit is ignored
    drive(mk(2'd2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5, 1, 0));
    bus.x_busy_query = 5;
    tick();
    check("fu2_inflight", 64'(bus.x_inflight), 0);
    check("fu2_busy", 64'(bus.x_busy), 0);
    idle();
    tick();
    check("fu2_inflight2", 64'(bus.x_inflight), 0);

    // Back-to-back r8, r8, r9
    bus.x_busy_query = 8;
    drive(op_rd(8, 1)); tick();
    drive(op_rd(8, 2)); tick();
    check("b2b_busy", 64'(bus.x_busy), 1);
    check("b2b_busy_cyc", 64'(bus.x_busy_cycles), 3);
    check("b2b_inflight2", 64'(bus.x_inflight), 2);
    drive(op_rd(9, 3)); tick();
    check("b2b_inflight3", 64'(bus.x_inflight), 3);
    check("b2b_busy_cyc_r9", 64'(bus.x_busy_cycles), 2);
    idle();
    for (int i = 0; i < 4; i++) tick();
    check("b2b_drained", 64'(bus.x_inflight), 0);
    check("b2b_busy_off", 64'(bus.x_busy), 0);
    drain();

    // Flush with the oldest op sitting at writeback
    for (int i = 0; i < 4; i++) begin drive(op_rd(REG_W'(10 + i), 32'(i))); tick(); end
    drive(op_rd(14, 9));
    bus.x_flush = 1'b1;
    #1;
    check("flush_wb_wr", 64'(bus.x_wb_writereg), 1);
    check("flush_wb_rd", 64'(bus.x_wb_regdest), 10);
    tick();
    idle();
    check("flush_inflight", 64'(bus.x_inflight), 0);
    for (int i = 0; i < STAGES; i++) begin
      check("flush_no_wb", 64'(bus.x_wb_writereg), 0);
      tick();
    end

    // Asynchronous reset mid-stream
    bus.x_busy_query = 21;
    for (int i = 0; i < 4; i++) begin drive(op_rd(REG_W'(20 + i), 32'h100)); tick(); end
    idle();
    check("arst_pre_wr", 64'(bus.x_wb_writereg), 1);
    check("arst_pre_busy", 64'(bus.x_busy), 1);
    #2 reset = 1'b0;
    #1;
    exp_q.delete();
    age_q.delete();
    check("arst_wb_wr", 64'(bus.x_wb_writereg), 0);
    check("arst_wb_rd", 64'(bus.x_wb_regdest), 0);
    check("arst_wb_val", 64'(bus.x_wb_wbvalue), 0);
    check("arst_inflight", 64'(bus.x_inflight), 0);
    check("arst_busy", 64'(bus.x_busy), 0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      tick();
      check("arst_no_wb", 64'(bus.x_wb_writereg), 0);
    end

    // Op at writeback stage: excluded from busy, visible to forwarding
    bus.x_busy_query = 7;
    drive(op_rd(7, 32'h54)); tick(); idle();
    tick(); tick();
    check("wbst_busy_age3", 64'(bus.x_busy), 1);
    check("wbst_cyc_age3", 64'(bus.x_busy_cycles), 1);
    tick();
    check("wbst_busy", 64'(bus.x_busy), 0);
`ifdef EXECUTE_PIPE_FWD_EN
    check("fwd_valid_wb", 64'(bus.x_fwd_valid), 1);
    check("fwd_value_wb", 64'(bus.x_fwd_value), 32'h55);
`else
    check("fwd_valid_off", 64'(bus.x_fwd_valid), 0);
    check("fwd_value_off", 64'(bus.x_fwd_value), 0);
`endif
    bus.x_busy_query = 0;
    drive(op_rd(0, 32'h99)); tick(); idle();
    check("r0_busy", 64'(bus.x_busy), 0);
    check("r0_fwd_valid", 64'(bus.x_fwd_valid), 0);
    drain();

    // Random traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      issue_t o;
      logic [31:0] pool[5];
      pool[0] = 0; pool[1] = 1; pool[2] = 32'h7FFFFFFF; pool[3] = 32'h80000000; pool[4] = 32'hFFFFFFFF;
      o = mk(($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd1,
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
             ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 4)] : $urandom(),
             ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 4)] : $urandom(),
             $urandom(), REG_W'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)));
      drive(o);
      bus.x_flush = ($urandom_range(0, 19) == 0);
      bus.x_busy_query = REG_W'($urandom_range(0, 7));
      tick();
      check_model("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
